// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 DIF single-delay-feedback FFT stage:
// butterfly/fill select, twiddle ROM addressing, end-of-frame drain.
module sdf_stage_ctrl #(
  parameter int N     = 256,
  parameter int SIZE  = 8,
  parameter int STAGE = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic            bf_sel,
  output logic            drain,
  output logic            tw_en,
  output logic [SIZE-2:0] tw_addr,
  output logic            out_valid,
  output logic            out_last,
  output logic            busy,
  output logic            err
);

  localparam int D  = N >> STAGE;
  localparam int PB = SIZE - STAGE;
  localparam int AW = SIZE - 1;
  localparam logic [SIZE-1:0] DM   = SIZE'(D - 1);
  localparam logic [SIZE-1:0] LAST = SIZE'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  state_e          state_q;
  logic [SIZE-1:0] cnt_q;
  logic [SIZE-1:0] k_q;
  logic            primed_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic            err_q;

  logic            flush;
  logic            acc;
  logic            p;
  logic            k_end;
  logic            f_end;
  logic [AW-1:0]   j_sh;
  logic [AW-1:0]   k_sh;

  assign flush    = (state_q == FLUSH);
  assign in_ready = !flush;
  assign acc      = in_valid & in_ready;
  assign p        = cnt_q[PB];
  assign k_end    = (k_q == DM);
  assign f_end    = (cnt_q == LAST);
  assign j_sh     = AW'((cnt_q & DM) << (STAGE - 1));
  assign k_sh     = AW'(k_q << (STAGE - 1));

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

  always_comb begin
    bf_sel  = 1'b0;
    drain   = 1'b0;
    tw_en   = 1'b0;
    tw_addr = '0;
    unique case (1'b1)
      flush: begin
        drain   = 1'b1;
        tw_en   = 1'b1;
        tw_addr = k_sh;
      end
      acc: begin
        bf_sel = p;
        // Block 0 feeds only the delay line; no rotated output yet.
        if (primed_q && !p) begin
          tw_en   = 1'b1;
          tw_addr = j_sh;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= (acc & primed_q) | flush;
      out_last_q  <= flush & k_end;
      unique case (state_q)
        FLUSH: begin
          if (k_end) begin
            k_q     <= '0;
            state_q <= IDLE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: begin
          if (acc) begin
            if (f_end) begin
              cnt_q    <= '0;
              primed_q <= 1'b0;
              k_q      <= '0;
              state_q  <= FLUSH;
              if (!in_last) err_q <= 1'b1;
            end else if (in_last) begin
              err_q    <= 1'b1;
              cnt_q    <= '0;
              primed_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= RUN;
              if (cnt_q == DM) primed_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: STAGE=6 and STAGE=8 instances against a
// sample-count model, plus literal frame-level expectations.
module tb_sdf_stage_ctrl;

  localparam int N = 256;

  logic       clk;
  logic       v  [2];
  logic       l  [2];
  logic       r  [2];
  logic       rdy[2];
  logic       bf [2];
  logic       dr [2];
  logic       te [2];
  logic [6:0] ta [2];
  logic       ov [2];
  logic       ol [2];
  logic       bs [2];
  logic       er [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int m_n [2];
  int m_k [2];
  int m_fa[2];
  bit m_fl[2];
  bit m_run[2];
  bit m_err[2];
  bit m_ov[2];
  bit m_ol[2];

  int ovc[2];
  int olc[2];
  int fc [2];
  int first_at[2];
  int fq0[$];

  sdf_stage_ctrl #(.N(256), .SIZE(8), .STAGE(6)) u0 (
    .clk(clk), .rst(r[0]), .in_valid(v[0]), .in_last(l[0]),
    .in_ready(rdy[0]), .bf_sel(bf[0]), .drain(dr[0]), .tw_en(te[0]),
    .tw_addr(ta[0]), .out_valid(ov[0]), .out_last(ol[0]),
    .busy(bs[0]), .err(er[0]));

  sdf_stage_ctrl #(.N(256), .SIZE(8), .STAGE(8)) u1 (
    .clk(clk), .rst(r[1]), .in_valid(v[1]), .in_last(l[1]),
    .in_ready(rdy[1]), .bf_sel(bf[1]), .drain(dr[1]), .tw_en(te[1]),
    .tw_addr(ta[1]), .out_valid(ov[1]), .out_last(ol[1]),
    .busy(bs[1]), .err(er[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] expv(input int d);
    int dl = d ? 1 : 4;
    int sh = d ? 7 : 5;
    logic rd = !m_fl[d];
    logic ac = v[d] & rd;
    logic b = 1'b0;
    logic dn = 1'b0;
    logic t = 1'b0;
    logic [6:0] a = '0;
    if (m_fl[d]) begin
      dn = 1'b1;
      t  = 1'b1;
      a  = 7'(m_k[d] << sh);
    end else if (ac) begin
      b = ((m_n[d] / dl) % 2) == 1;
      if (!b && m_n[d] >= dl) begin
        t = 1'b1;
        a = 7'((m_n[d] % dl) << sh);
      end
    end
    return {rd, b, dn, t, a, m_run[d] | m_fl[d], m_err[d], m_ov[d], m_ol[d]};
  endfunction

  task automatic model_upd(input int d);
    int dl = d ? 1 : 4;
    bit ac = v[d] && !m_fl[d];
    if (r[d]) begin
      m_n[d] = 0; m_k[d] = 0; m_fl[d] = 0; m_run[d] = 0;
      m_err[d] = 0; m_ov[d] = 0; m_ol[d] = 0;
    end else begin
      m_ov[d] = (ac && m_n[d] >= dl) || m_fl[d];
      m_ol[d] = m_fl[d] && m_k[d] == dl - 1;
      if (m_fl[d]) begin
        if (m_k[d] == dl - 1) begin
          m_fl[d] = 0;
          m_run[d] = 0;
        end else begin
          m_k[d]++;
        end
      end else if (ac) begin
        m_fa[d]++;
        if (m_n[d] == N - 1) begin
          if (!l[d]) m_err[d] = 1;
          m_n[d] = 0;
          m_fl[d] = 1;
          m_k[d] = 0;
        end else if (l[d]) begin
          m_err[d] = 1;
          m_n[d] = 0;
          m_run[d] = 0;
        end else begin
          m_n[d]++;
          m_run[d] = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [14:0] got;
      logic [14:0] want;
      got  = {rdy[d], bf[d], dr[d], te[d], ta[d], bs[d], er[d], ov[d], ol[d]};
      want = expv(d);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL outputs dut%0d cyc %0d got %h want %h", d, cyc, got, want);
      end
      if (ov[d] === 1'b1) begin
        ovc[d]++;
        if (first_at[d] < 0) first_at[d] = m_fa[d];
      end
      if (ol[d] === 1'b1) olc[d]++;
      if (dr[d] === 1'b1) begin
        fc[d]++;
        if (d == 0) fq0.push_back(int'(ta[0]));
      end
    end
    @(posedge clk);
    model_upd(0);
    model_upd(1);
    cyc++;
    #1;
  endtask

  task automatic lit(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic clr(input int d);
    ovc[d] = 0; olc[d] = 0; fc[d] = 0; first_at[d] = -1; m_fa[d] = 0;
    if (d == 0) fq0.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame(input int d, input int len, input int last_at, input bit gaps);
    int idx = 0;
    int c = 0;
    int pre;
    while (idx < len && c < 4000) begin
      v[d] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      l[d] = (idx == last_at);
      pre = m_fa[d];
      step();
      if (m_fa[d] != pre) idx++;
      c++;
    end
    v[d] = 1'b0;
    l[d] = 1'b0;
    if (idx < len) begin
      miscompares++;
      $display("FAIL frame_timeout dut%0d got %0d want %0d", d, idx, len);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      v[d] = 0; l[d] = 0; r[d] = 1;
      m_fa[d] = 0;
      clr(d);
    end
    step();
    step();
    r[0] = 0;
    r[1] = 0;
    idle(2);
    lit("reset_busy", int'(bs[0]), 0);
    lit("reset_ov", int'(ov[0]), 0);
    lit("reset_ready", int'(rdy[0]), 1);

    clr(0);
    frame(0, 256, 255, 0);
    idle(8);
    lit("gapless_ov_count", ovc[0], 256);
    lit("gapless_last_count", olc[0], 1);
    lit("first_pulse_after", first_at[0], 5);
    lit("flush_len", fq0.size(), 4);
    for (int i = 0; i < 4 && i < fq0.size(); i++)
      lit("flush_addr", fq0[i], 32 * i);
    lit("gapless_err", int'(er[0]), 0);

    for (int f = 0; f < 2; f++) begin
      clr(0);
      frame(0, 256, 255, 1);
      idle(8);
      lit("gaps_ov_count", ovc[0], 256);
      lit("gaps_last_count", olc[0], 1);
    end

    clr(0);
    frame(0, 101, 100, 0);
    idle(1);
    lit("early_last_err", int'(er[0]), 1);
    lit("early_last_busy", int'(bs[0]), 0);
    idle(4);
    lit("early_last_nodrain", fc[0], 0);
    clr(0);
    frame(0, 256, 255, 0);
    idle(8);
    lit("after_err_ov_count", ovc[0], 256);
    lit("err_sticky", int'(er[0]), 1);

    frame(0, 131, -1, 0);
    r[0] = 1;
    step();
    r[0] = 0;
    lit("rst_ov", int'(ov[0]), 0);
    lit("rst_busy", int'(bs[0]), 0);
    lit("rst_err", int'(er[0]), 0);
    clr(0);
    frame(0, 256, 255, 0);
    idle(8);
    lit("post_rst_ov_count", ovc[0], 256);
    lit("post_rst_first", first_at[0], 5);

    clr(1);
    frame(1, 256, 255, 0);
    idle(4);
    lit("d1_ov_count", ovc[1], 256);
    lit("d1_last_count", olc[1], 1);
    lit("d1_flush_len", fc[1], 1);
    lit("d1_first_pulse", first_at[1], 2);
    lit("d1_err", int'(er[1]), 0);

    clr(1);
    frame(1, 256, -1, 1);
    idle(4);
    lit("nolast_ov_count", ovc[1], 256);
    lit("nolast_err", int'(er[1]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
